// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end with credit-limited in-order request/response tracking
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst_pc,
    output logic [XLEN-1:0] inst_data,
    input  logic            inst_ready
);

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int LIVE_W = CNT_W + 2;

    logic [XLEN-1:0]   fetch_pc;
    logic [XLEN-1:0]   pcq_mem [DEPTH];
    logic [PTR_W-1:0]  pcq_rd;
    logic [PTR_W-1:0]  pcq_wr;
    logic [CNT_W-1:0]  pcq_cnt;
    logic [XLEN-1:0]   fifo_pc   [DEPTH];
    logic [XLEN-1:0]   fifo_data [DEPTH];
    logic [PTR_W-1:0]  fifo_rd;
    logic [PTR_W-1:0]  fifo_wr;
    logic [CNT_W-1:0]  fifo_cnt;
    logic [CNT_W-1:0]  drop_cnt;
    logic [LIVE_W-1:0] live;
    logic              req_fire;
    logic              resp_drop;
    logic              resp_take;
    logic              inst_pop;
    logic              unused_pc_lsbs;

    // Every issued-but-unretired fetch holds a credit: tracked address, buffered word or pending drop.
    assign live           = LIVE_W'(pcq_cnt) + LIVE_W'(fifo_cnt) + LIVE_W'(drop_cnt);
    assign imem_req_valid = !reset && !redirect_valid && (live < LIVE_W'(DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Older squashed responses always arrive before responses to live requests.
    assign resp_drop      = imem_resp_valid && (drop_cnt != '0);
    assign resp_take      = imem_resp_valid && (drop_cnt == '0) && (pcq_cnt != '0);

    assign inst_valid     = (fifo_cnt != '0);
    assign inst_pop       = inst_valid && inst_ready;
    assign inst_pc        = fifo_pc[fifo_rd];
    assign inst_data      = fifo_data[fifo_rd];

    assign unused_pc_lsbs = ^redirect_pc[1:0];

    // PC, address tracking queue, instruction buffer and squash counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            pcq_rd   <= '0;
            pcq_wr   <= '0;
            pcq_cnt  <= '0;
            fifo_rd  <= '0;
            fifo_wr  <= '0;
            fifo_cnt <= '0;
            drop_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pcq_mem[i]   <= '0;
                fifo_pc[i]   <= '0;
                fifo_data[i] <= '0;
            end
        end else if (redirect_valid) begin
            // Anything still outstanding after this cycle's response becomes a drop.
            fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            drop_cnt <= drop_cnt - CNT_W'(resp_drop) + pcq_cnt - CNT_W'(resp_take);
            pcq_rd   <= '0;
            pcq_wr   <= '0;
            pcq_cnt  <= '0;
            fifo_rd  <= '0;
            fifo_wr  <= '0;
            fifo_cnt <= '0;
        end else begin
            if (req_fire) begin
                pcq_mem[pcq_wr] <= fetch_pc;
                pcq_wr          <= pcq_wr + PTR_W'(1);
                fetch_pc        <= fetch_pc + XLEN'(4);
            end
            if (resp_take) begin
                pcq_rd             <= pcq_rd + PTR_W'(1);
                fifo_pc[fifo_wr]   <= pcq_mem[pcq_rd];
                fifo_data[fifo_wr] <= imem_resp_data;
                fifo_wr            <= fifo_wr + PTR_W'(1);
            end
            if (inst_pop) begin
                fifo_rd <= fifo_rd + PTR_W'(1);
            end
            pcq_cnt  <= pcq_cnt + CNT_W'(req_fire) - CNT_W'(resp_take);
            fifo_cnt <= fifo_cnt + CNT_W'(resp_take) - CNT_W'(inst_pop);
            drop_cnt <= drop_cnt - CNT_W'(resp_drop);
        end
    end

    // A response with nothing outstanding means the memory broke ordering or invented a reply.
    resp_has_owner: assert property (@(posedge clk) disable iff (reset)
        imem_resp_valid |-> ((drop_cnt != '0) || (pcq_cnt != '0)));

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic [31:0] inst_pc;
    logic [31:0] inst_data;
    logic        inst_ready;

    fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst_pc         (inst_pc),
        .inst_data       (inst_data),
        .inst_ready      (inst_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // memory model: accepted addresses with the cycle they may be answered
    typedef struct { logic [31:0] addr; int unsigned due; } mreq_t;
    mreq_t mem_q[$];
    int unsigned cyc = 0;
    int unsigned lat_lo = 1;
    int unsigned lat_hi = 1;
    int unsigned resp_pct = 100;

    // reference model: requests in issue order (stale = squashed) and delivered words
    typedef struct { logic [31:0] addr; bit stale; } out_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } buf_t;
    out_t        outq[$];
    buf_t        bufq[$];
    logic [31:0] m_pc = RESET_PC;

    // values sampled in the last step
    bit          s_rv, s_iv, s_resp;
    logic [31:0] s_addr, s_pc, s_data;

    typedef struct { bit irdy; bit e_rv; logic [31:0] e_addr; bit e_iv; logic [31:0] e_pc; } vec_t;
    vec_t t1[7];
    vec_t t2[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        outq.delete();
        bufq.delete();
        mem_q.delete();
        m_pc = RESET_PC;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0; inst_ready = 1'b0;
        repeat (n) @(negedge clk);
        #1;
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_req_addr", imem_req_addr, RESET_PC);
        chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        chk("rst_inst_data", inst_data, 32'd0);
        model_clear();
    endtask

    // one clock cycle: drive, sample, compare with model, advance model and memory
    task automatic step(input bit rst, input bit redir, input logic [31:0] rpc, input bit rdy, input bit irdy);
        bit   rv_exp, iv_exp;
        out_t o;
        @(negedge clk);
        reset = rst; redirect_valid = redir; redirect_pc = rpc;
        imem_req_ready = rdy; inst_ready = irdy;
        s_resp = !rst && (mem_q.size() > 0) && (mem_q[0].due <= cyc) && ($urandom_range(99) < resp_pct);
        imem_resp_valid = s_resp;
        imem_resp_data  = s_resp ? (mem_q[0].addr ^ KEY) : $urandom;
        #1;
        s_rv = imem_req_valid; s_addr = imem_req_addr;
        s_iv = inst_valid; s_pc = inst_pc; s_data = inst_data;
        rv_exp = !rst && !redir && ((outq.size() + bufq.size()) < DEPTH);
        iv_exp = (bufq.size() > 0);
        chk("req_valid", {31'b0, s_rv}, {31'b0, rv_exp});
        chk("req_addr", s_addr, m_pc);
        chk("inst_valid", {31'b0, s_iv}, {31'b0, iv_exp});
        if (iv_exp) begin
            chk("inst_pc", s_pc, bufq[0].pc);
            chk("inst_data", s_data, bufq[0].data);
        end
        if (rst) begin
            model_clear();
        end else begin
            if (!redir && iv_exp && irdy) void'(bufq.pop_front());
            if (s_resp) begin
                void'(mem_q.pop_front());
                if (outq.size() > 0) begin
                    o = outq.pop_front();
                    if (!redir && !o.stale) bufq.push_back('{o.addr, imem_resp_data});
                end
            end
            if (s_rv && rdy) mem_q.push_back('{s_addr, cyc + $urandom_range(lat_hi, lat_lo)});
            if (redir) begin
                bufq.delete();
                foreach (outq[i]) outq[i].stale = 1'b1;
                m_pc = rpc & ~32'd3;
            end else if (rv_exp && rdy) begin
                outq.push_back('{m_pc, 1'b0});
                m_pc = m_pc + 32'd4;
            end
        end
        cyc++;
    endtask

    initial begin
        bit          found;
        int          nfire;
        logic [31:0] fires[3];
        logic [31:0] first_pc;

        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0;
        imem_resp_valid = 1'b0; imem_resp_data = '0; inst_ready = 1'b0;

        // startup with 1-cycle memory, decode always ready
        t1[0] = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        t1[1] = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
        t1[2] = '{1'b1, 1'b0, 32'h08, 1'b1, 32'h00};
        t1[3] = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h04};
        t1[4] = '{1'b1, 1'b1, 32'h0C, 1'b0, 32'h00};
        t1[5] = '{1'b1, 1'b0, 32'h10, 1'b1, 32'h08};
        t1[6] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h0C};
        // decode stalled: credits run out after two fetches, then drain and resume at 8
        t2[0] = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
        t2[1] = '{1'b0, 1'b1, 32'h04, 1'b0, 32'h00};
        t2[2] = '{1'b0, 1'b0, 32'h08, 1'b1, 32'h00};
        t2[3] = '{1'b0, 1'b0, 32'h08, 1'b1, 32'h00};
        t2[4] = '{1'b0, 1'b0, 32'h08, 1'b1, 32'h00};
        t2[5] = '{1'b1, 1'b0, 32'h08, 1'b1, 32'h00};
        t2[6] = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h04};
        t2[7] = '{1'b1, 1'b1, 32'h0C, 1'b0, 32'h00};

        do_reset(2);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b0, '0, 1'b1, t1[i].irdy);
            chk("t1_rv", {31'b0, s_rv}, {31'b0, t1[i].e_rv});
            chk("t1_addr", s_addr, t1[i].e_addr);
            chk("t1_iv", {31'b0, s_iv}, {31'b0, t1[i].e_iv});
            if (t1[i].e_iv) begin
                chk("t1_pc", s_pc, t1[i].e_pc);
                chk("t1_data", s_data, t1[i].e_pc ^ KEY);
            end
        end

        do_reset(2);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, '0, 1'b1, t2[i].irdy);
            chk("t2_rv", {31'b0, s_rv}, {31'b0, t2[i].e_rv});
            chk("t2_addr", s_addr, t2[i].e_addr);
            chk("t2_iv", {31'b0, s_iv}, {31'b0, t2[i].e_iv});
            if (t2[i].e_iv) chk("t2_pc", s_pc, t2[i].e_pc);
        end

        // redirect with two requests in flight (3-cycle memory)
        do_reset(2);
        lat_lo = 3; lat_hi = 3;
        step(1'b0, 1'b0, '0, 1'b1, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 32'h0000_0103, 1'b1, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1);
        chk("t3_stall_on_drops", {31'b0, s_rv}, 32'd0);
        found = 1'b0; first_pc = '0;
        for (int k = 0; k < 20 && !found; k++) begin
            step(1'b0, 1'b0, '0, 1'b1, 1'b1);
            if (s_iv) begin found = 1'b1; first_pc = s_pc; end
        end
        chk("t3_delivered", {31'b0, found}, 32'd1);
        chk("t3_first_pc", first_pc, 32'h0000_0100);

        // redirect coinciding with a response and a decode pop
        do_reset(2);
        lat_lo = 1; lat_hi = 1;
        step(1'b0, 1'b0, '0, 1'b1, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 32'h0000_0200, 1'b1, 1'b1);
        chk("t4_setup_resp", {31'b0, s_resp}, 32'd1);
        chk("t4_setup_iv", {31'b0, s_iv}, 32'd1);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1);
        chk("t4_fifo_empty", {31'b0, s_iv}, 32'd0);
        chk("t4_addr", s_addr, 32'h0000_0200);
        found = 1'b0; first_pc = '0;
        for (int k = 0; k < 20 && !found; k++) begin
            step(1'b0, 1'b0, '0, 1'b1, 1'b1);
            if (s_iv) begin found = 1'b1; first_pc = s_pc; end
        end
        chk("t4_first_pc", first_pc, 32'h0000_0200);

        // redirect near the top of the address space: PC wraps to zero
        do_reset(2);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
        nfire = 0;
        for (int k = 0; k < 30 && nfire < 3; k++) begin
            step(1'b0, 1'b0, '0, 1'b1, 1'b1);
            if (s_rv) begin fires[nfire] = s_addr; nfire++; end
        end
        chk("t5_nfire", nfire, 32'd3);
        chk("t5_req0", fires[0], 32'hFFFF_FFF8);
        chk("t5_req1", fires[1], 32'hFFFF_FFFC);
        chk("t5_req2", fires[2], 32'h0000_0000);

        // back-to-back redirects: last one wins
        do_reset(2);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 32'h0000_0300, 1'b1, 1'b1);
        step(1'b0, 1'b1, 32'h0000_0400, 1'b1, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1);
        chk("t7_addr", s_addr, 32'h0000_0400);
        found = 1'b0; first_pc = '0;
        for (int k = 0; k < 20 && !found; k++) begin
            step(1'b0, 1'b0, '0, 1'b1, 1'b1);
            if (s_iv) begin found = 1'b1; first_pc = s_pc; end
        end
        chk("t7_first_pc", first_pc, 32'h0000_0400);

        // reset with one buffered word and one request outstanding
        do_reset(2);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 1'b0, '0, 1'b1, 1'b0);
        do_reset(1);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1);
        chk("t6_iv", {31'b0, s_iv}, 32'd0);
        chk("t6_rv", {31'b0, s_rv}, 32'd1);
        chk("t6_addr", s_addr, RESET_PC);

        // randomized traffic against the reference model
        lat_lo = 1; lat_hi = 4; resp_pct = 75;
        for (int k = 0; k < 3000; k++) begin
            bit          rst, rd;
            logic [31:0] rp;
            rst = ($urandom_range(255) == 0);
            rd  = ($urandom_range(15) == 0);
            rp  = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
            step(rst, rd, rp, $urandom_range(3) != 0, $urandom_range(2) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
